scr_brk_bod_checker_n: RTL
==========================

Name: scr_brk_bod_checker_n

Overview:
- Generalised N-channel SCR breakdown/BOD checker for the LE check board.
- One shared optical breakdown-feedback signal is debounced, then edge-detected.
- Each trigger channel runs its own timed window FSM. It reports a BOD hit (feedback edge early in the window) and a breakdown result (no feedback edge in the late window), cross-mapped to the partner channel.
- Adds over the fixed two-channel block: async reset, channel count, window, filter and counter widths as parameters, sticky-latch mode, result strobes and saturating per-channel fault counters.

Parameters:
- CH, 2: trigger channel count; must be even. Channels pair as i and i^1.
- CNT_W, 20: window counter width; must hold T_BRK+5.
- T_BOD, 25000: end of BOD window in clocks (500 us at 50 MHz).
- T_GAP, 42400: end of blanking gap (848 us).
- T_BRK, 900000: end of breakdown window (18 ms).
- FILT_LEN, 8: stable cycles required by the feedback debounce filter; minimum 2.
- STICKY, 0: 1 = outputs hold 1 once set, until i_clr_sticky.
- FCNT_W, 8: fault counter width per channel.

Ports:
- i_clk_50m, in, 1: 50 MHz clock.
- i_rst_n, in, 1: reset, asynchronous, active-low.
- i_signal, in, 1: raw breakdown feedback, asynchronous.
- i_trig, in, CH: trigger pulses, asynchronous, one per channel.
- i_signal_forbid, in, 1: pulse inhibit; 1 = forbid.
- i_clr_sticky, in, 1: clears sticky outputs; synchronous, level.
- o_brk, out, CH: breakdown flag; 1 = action.
- o_bod, out, CH: BOD flag; 1 = action.
- o_valid, out, CH: one-cycle strobe when channel i latches its result.
- o_fault_cnt, out, CH*FCNT_W: saturating fault count; channel i occupies bits [i*FCNT_W +: FCNT_W].

Behaviour:
- Reset (i_rst_n=0, async):
  - o_brk, o_bod = all 1; o_valid = 0; o_fault_cnt = 0.
  - All FSMs go to IDLE; counters and hit flags = 0; sync/filter registers = 0.
- Input conditioning:
  - i_signal and each i_trig pass through a 2-FF synchroniser.
  - Filtered feedback f_sig changes only after the synchronised input differs from f_sig for FILT_LEN consecutive cycles.
  - f_rise = f_sig & ~f_sig_d. Latency from raw edge to f_rise is 2+FILT_LEN+1 cycles.
  - Trigger rising edge = sync & ~sync_d. sync_d updates every cycle, including during forbid.
- Forbid (i_signal_forbid=1, sampled synchronously):
  - Every cycle: o_brk, o_bod = all 1; o_valid = 0; all FSMs forced to IDLE; counters and hit flags cleared.
  - o_fault_cnt is held.
  - A trigger held high across forbid release does not start a window; only a new rising edge does.
- Per-channel FSM, counter cnt:
  - IDLE: on trigger rising edge, cnt=1 and go to BOD. Clear bod_hit and brk_seen.
  - BOD (1<=cnt<=T_BOD): f_rise sets bod_hit.
  - GAP (T_BOD<cnt<=T_GAP): f_rise ignored.
  - BRK (T_GAP<cnt<=T_BRK): f_rise sets brk_seen.
  - TAIL (T_BRK<cnt<=T_BRK+5): at cnt==T_BRK+2, latch:
    - o_bod[i] <= bod_hit;
    - o_brk[i^1] <= ~brk_seen;
    - o_valid[i] = 1 for one cycle.
  - At cnt==T_BRK+5: cnt=0, go to IDLE.
  - cnt increments by 1 every cycle outside IDLE.
  - Trigger rising edges outside IDLE are ignored; there is no restart.
- STICKY=1:
  - A latch writes old|new.
  - i_clr_sticky=1 clears o_brk and o_bod to 0.
  - If clear and latch occur in the same cycle for the same bit, the new latched value is written without the OR.
  - STICKY=0: i_clr_sticky has no effect.
- Fault counter[i]:
  - Increments at channel i's latch if bod_hit | ~brk_seen.
  - Saturates at 2^FCNT_W-1; cleared only by reset.
- Channels are independent. Simultaneous latches of i and i^1 in one cycle update disjoint output bits and both apply.
- o_valid is never asserted during forbid or reset.

Test Plan:
- Trigger on ch0; f_sig pulse at cnt~10000; no pulse in BRK window -> at cnt=T_BRK+2: o_bod[0]=1, o_brk[1]=1, o_valid[0] strobe; fault_cnt[0]=1.
- Trigger on ch1; feedback pulse at cnt~500000 only -> o_bod[1]=0, o_brk[0]=0; fault_cnt[1] unchanged at 0.
- Feedback glitch of FILT_LEN-1 cycles inside the BOD window -> no f_rise; o_bod stays 0. A FILT_LEN+2 cycle pulse -> o_bod=1.
- Forbid asserted at cnt=30000 on ch0 -> outputs forced all 1 next cycle, FSM in IDLE, no o_valid. Release with trigger still high -> no new window until the next rising edge.
- Small-param build (T_BOD=10, T_GAP=20, T_BRK=40, FCNT_W=2), four faulting windows -> count 1,2,3,3 (saturated). Second trigger edge at cnt=15 -> ignored; latch occurs at cnt=42 of the first window.
- STICKY=1: a faulting window then a clean window -> o_brk stays 1. i_clr_sticky in the same cycle as a faulting latch -> bit =1. Clear alone -> 0. Async reset mid-window -> outputs 1 immediately, counters 0.

Source files
------------

// File: rtl/scr_brk_bod_checker_n.sv
// N-channel SCR breakdown / BOD checker with debounced shared feedback.
// Each trigger channel runs a timed window; results cross-map to partner i^1.
module scr_brk_bod_checker_n #(
  parameter int CH       = 2,
  parameter int CNT_W    = 20,
  parameter int T_BOD    = 25000,
  parameter int T_GAP    = 42400,
  parameter int T_BRK    = 900000,
  parameter int FILT_LEN = 8,
  parameter int STICKY   = 0,
  parameter int FCNT_W   = 8
) (
  input  logic                 i_clk_50m,
  input  logic                 i_rst_n,
  input  logic                 i_signal,
  input  logic [CH-1:0]        i_trig,
  input  logic                 i_signal_forbid,
  input  logic                 i_clr_sticky,
  output logic [CH-1:0]        o_brk,
  output logic [CH-1:0]        o_bod,
  output logic [CH-1:0]        o_valid,
  output logic [CH*FCNT_W-1:0] o_fault_cnt
);

  localparam int FL_W = $clog2(FILT_LEN + 1);
  localparam logic [FL_W-1:0] FL_LAST = FL_W'(FILT_LEN - 1);
  localparam logic [CNT_W-1:0] C_BOD = CNT_W'(T_BOD);
  localparam logic [CNT_W-1:0] C_GAP = CNT_W'(T_GAP);
  localparam logic [CNT_W-1:0] C_BRK = CNT_W'(T_BRK);
  localparam logic [CNT_W-1:0] C_LAT = CNT_W'(T_BRK + 2);
  localparam logic [CNT_W-1:0] C_END = CNT_W'(T_BRK + 5);
  localparam logic [FCNT_W-1:0] FC_MAX = '1;
  localparam logic STK = (STICKY != 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_BOD,
    S_GAP,
    S_BRK,
    S_TAIL
  } state_t;

  logic            r_sig_s1;
  logic            r_sig_s2;
  logic            r_fsig;
  logic            r_fsig_d;
  logic [FL_W-1:0] r_flt_cnt;
  logic            w_frise;

  logic [CH-1:0] r_trig_s1;
  logic [CH-1:0] r_trig_s2;
  logic [CH-1:0] r_trig_d;
  logic [CH-1:0] w_trig_rise;

  state_t           r_state     [CH];
  state_t           w_state_nxt [CH];
  logic [CNT_W-1:0] r_cnt       [CH];
  logic [CNT_W-1:0] w_cnt_nxt   [CH];
  logic [CH-1:0]    r_bod_hit;
  logic [CH-1:0]    r_brk_seen;
  logic [CH-1:0]    w_bod_hit_nxt;
  logic [CH-1:0]    w_brk_seen_nxt;
  logic [CH-1:0]    w_latch;

  logic [CH-1:0]     r_bod;
  logic [CH-1:0]     r_brk;
  logic [CH-1:0]     r_valid;
  logic [CH-1:0]     w_bod_nxt;
  logic [CH-1:0]     w_brk_nxt;
  logic              w_or_old;
  logic [FCNT_W-1:0] r_fcnt [CH];

  // feedback: 2-FF sync, then FILT_LEN-cycle stability filter
  always_ff @(posedge i_clk_50m or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sig_s1  <= 1'b0;
      r_sig_s2  <= 1'b0;
      r_fsig    <= 1'b0;
      r_fsig_d  <= 1'b0;
      r_flt_cnt <= '0;
    end else begin
      r_sig_s1 <= i_signal;
      r_sig_s2 <= r_sig_s1;
      r_fsig_d <= r_fsig;
      if (r_sig_s2 != r_fsig) begin
        if (r_flt_cnt == FL_LAST) begin
          r_fsig    <= r_sig_s2;
          r_flt_cnt <= '0;
        end else begin
          r_flt_cnt <= r_flt_cnt + 1'b1;
        end
      end else begin
        r_flt_cnt <= '0;
      end
    end
  end

  assign w_frise = r_fsig & ~r_fsig_d;

  always_ff @(posedge i_clk_50m or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_trig_s1 <= '0;
      r_trig_s2 <= '0;
      r_trig_d  <= '0;
    end else begin
      r_trig_s1 <= i_trig;
      r_trig_s2 <= r_trig_s1;
      r_trig_d  <= r_trig_s2;
    end
  end

  assign w_trig_rise = r_trig_s2 & ~r_trig_d;

  always_comb begin
    for (int i = 0; i < CH; i++) begin
      w_state_nxt[i]    = r_state[i];
      w_cnt_nxt[i]      = r_cnt[i];
      w_bod_hit_nxt[i]  = r_bod_hit[i];
      w_brk_seen_nxt[i] = r_brk_seen[i];
      w_latch[i]        = 1'b0;
      if (r_state[i] != S_IDLE) begin
        w_cnt_nxt[i] = r_cnt[i] + 1'b1;
      end
      case (r_state[i])
        S_IDLE: begin
          if (w_trig_rise[i]) begin
            w_state_nxt[i]    = S_BOD;
            w_cnt_nxt[i]      = CNT_W'(1);
            w_bod_hit_nxt[i]  = 1'b0;
            w_brk_seen_nxt[i] = 1'b0;
          end
        end
        S_BOD: begin
          if (w_frise) w_bod_hit_nxt[i] = 1'b1;
          if (r_cnt[i] == C_BOD) w_state_nxt[i] = S_GAP;
        end
        S_GAP: begin
          if (r_cnt[i] == C_GAP) w_state_nxt[i] = S_BRK;
        end
        S_BRK: begin
          if (w_frise) w_brk_seen_nxt[i] = 1'b1;
          if (r_cnt[i] == C_BRK) w_state_nxt[i] = S_TAIL;
        end
        S_TAIL: begin
          if (r_cnt[i] == C_LAT) w_latch[i] = 1'b1;
          if (r_cnt[i] == C_END) begin
            w_state_nxt[i] = S_IDLE;
            w_cnt_nxt[i]   = '0;
          end
        end
        default: begin
          w_state_nxt[i] = S_IDLE;
          w_cnt_nxt[i]   = '0;
        end
      endcase
      if (i_signal_forbid) begin
        w_state_nxt[i]    = S_IDLE;
        w_cnt_nxt[i]      = '0;
        w_bod_hit_nxt[i]  = 1'b0;
        w_brk_seen_nxt[i] = 1'b0;
        w_latch[i]        = 1'b0;
      end
    end
  end

  always_ff @(posedge i_clk_50m or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < CH; i++) begin
        r_state[i] <= S_IDLE;
        r_cnt[i]   <= '0;
      end
      r_bod_hit  <= '0;
      r_brk_seen <= '0;
    end else begin
      for (int i = 0; i < CH; i++) begin
        r_state[i] <= w_state_nxt[i];
        r_cnt[i]   <= w_cnt_nxt[i];
      end
      r_bod_hit  <= w_bod_hit_nxt;
      r_brk_seen <= w_brk_seen_nxt;
    end
  end

  // a clear in the latch cycle wins over the old value, not over the new one
  assign w_or_old = STK & ~i_clr_sticky;

  always_comb begin
    w_bod_nxt = r_bod;
    w_brk_nxt = r_brk;
    if (STK && i_clr_sticky) begin
      w_bod_nxt = '0;
      w_brk_nxt = '0;
    end
    for (int i = 0; i < CH; i++) begin
      if (w_latch[i]) begin
        w_bod_nxt[i]     = r_bod_hit[i] | (w_or_old & r_bod[i]);
        w_brk_nxt[i ^ 1] = ~r_brk_seen[i] | (w_or_old & r_brk[i ^ 1]);
      end
    end
    if (i_signal_forbid) begin
      w_bod_nxt = '1;
      w_brk_nxt = '1;
    end
  end

  always_ff @(posedge i_clk_50m or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_bod   <= '1;
      r_brk   <= '1;
      r_valid <= '0;
      for (int i = 0; i < CH; i++) begin
        r_fcnt[i] <= '0;
      end
    end else begin
      r_bod   <= w_bod_nxt;
      r_brk   <= w_brk_nxt;
      r_valid <= w_latch;
      for (int i = 0; i < CH; i++) begin
        if (w_latch[i] && (r_bod_hit[i] || !r_brk_seen[i])
            && r_fcnt[i] != FC_MAX) begin
          r_fcnt[i] <= r_fcnt[i] + 1'b1;
        end
      end
    end
  end

  assign o_bod   = r_bod;
  assign o_brk   = r_brk;
  assign o_valid = r_valid & {CH{~i_signal_forbid}};

  for (genvar g = 0; g < CH; g++) begin : g_fc
    assign o_fault_cnt[g*FCNT_W +: FCNT_W] = r_fcnt[g];
  end

endmodule
